// File: rtl/bk_adder_pkg.sv
// rtl/bk_adder_pkg.sv - shared mode codes, level helper and stage payload for the Brent-Kung adder
package bk_adder_pkg;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // ceil(log2(n)); the number of up-sweep levels for an n-bit prefix
  function automatic int lvl_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic       valid;
    logic [1:0] mode;
    logic       a_msb;
    logic       bp_msb;
    logic       cin;
  } stage_t;

endpackage

// File: rtl/bk_prefix_net.sv
// rtl/bk_prefix_net.sv - combinational Brent-Kung (g,p) prefix over levels [LVL_LO, LVL_HI)
// Levels 0..L-1 are the up-sweep, L..2L-2 the down-sweep; levels outside the range pass through.
module bk_prefix_net import bk_adder_pkg::*; #(
  parameter int WIDTH  = 16,
  parameter int LVL_LO = 0,
  parameter int LVL_HI = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  localparam int L    = lvl_log2(WIDTH);
  localparam int NLEV = 2 * L - 1;

  logic [NLEV:0][WIDTH-1:0] g_l;
  logic [NLEV:0][WIDTH-1:0] p_l;

  assign g_l[0] = g_in;
  assign p_l[0] = p_in;

  for (genvar k = 0; k < NLEV; k++) begin : g_lvl
    localparam int LV = (k < L) ? k : (2 * L - 2 - k);
    localparam int D  = 1 << LV;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      // up-sweep merges the top of each 2D block; down-sweep fills the midpoints above the first block
      localparam bit UP  = ((i + 1) % (2 * D)) == 0;
      localparam bit DN  = (((i + 1) % (2 * D)) == D) && ((i + 1) > (2 * D));
      localparam bit ACT = (k >= LVL_LO) && (k < LVL_HI) && ((k < L) ? UP : DN);
      if (ACT) begin : g_op
        assign g_l[k+1][i] = g_l[k][i] | (p_l[k][i] & g_l[k][i-D]);
        assign p_l[k+1][i] = p_l[k][i] & p_l[k][i-D];
      end else begin : g_pass
        assign g_l[k+1][i] = g_l[k][i];
        assign p_l[k+1][i] = p_l[k][i];
      end
    end
  end

  assign g_out = g_l[NLEV];
  assign p_out = p_l[NLEV];

endmodule

// File: rtl/bk_pipe_adder.sv
// rtl/bk_pipe_adder.sv - pipelined Brent-Kung adder with sub/accumulate/load modes and ACC interlock
module bk_pipe_adder import bk_adder_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] acc
);

  localparam int L    = lvl_log2(WIDTH);
  localparam int NLEV = 2 * L - 1;

  logic [1:0]       busy;
  logic             take;
  logic [WIDTH-1:0] bp;
  logic             c;

  assign in_ready = (busy == 2'd0);
  assign take     = in_valid && in_ready;

  // LOAD becomes a + 0 + 0 so it shares the adder path and yields cout=0, ovf=0
  always_comb begin
    bp = b;
    c  = cin;
    case (mode)
      MODE_SUB:  begin bp = ~b;  c = 1'b1; end
      MODE_ACC:  bp = acc;
      MODE_LOAD: begin bp = '0;  c = 1'b0; end
      default:   ;
    endcase
  end

  stage_t           pl0, pl1, pl2;
  logic [WIDTH-1:0] g0, p0, g1, p1, gu, pu, g2, p2, pb2, gd, pd, sum;
  logic             co, ov;

  // carry-in is folded into bit 0's generate so the prefix yields true carries
  assign pl0 = {take, mode, a[WIDTH-1], bp[WIDTH-1], c};
  assign p0  = a ^ bp;
  assign g0  = (a & bp) | {{(WIDTH-1){1'b0}}, p0[0] & c};

  if (PIPE == 2) begin : g_cut_pre
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pl1 <= '0;
        g1  <= '0;
        p1  <= '0;
      end else begin
        pl1 <= pl0;
        g1  <= g0;
        p1  <= p0;
      end
    end
  end else begin : g_thru_pre
    assign pl1 = pl0;
    assign g1  = g0;
    assign p1  = p0;
  end

  bk_prefix_net #(.WIDTH(WIDTH), .LVL_LO(0), .LVL_HI(L)) u_up (
    .g_in  (g1),
    .p_in  (p1),
    .g_out (gu),
    .p_out (pu)
  );

  if (PIPE >= 1) begin : g_cut_up
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pl2 <= '0;
        g2  <= '0;
        p2  <= '0;
        pb2 <= '0;
      end else begin
        pl2 <= pl1;
        g2  <= gu;
        p2  <= pu;
        pb2 <= p1;
      end
    end
  end else begin : g_thru_up
    assign pl2 = pl1;
    assign g2  = gu;
    assign p2  = pu;
    assign pb2 = p1;
  end

  bk_prefix_net #(.WIDTH(WIDTH), .LVL_LO(L), .LVL_HI(NLEV)) u_dn (
    .g_in  (g2),
    .p_in  (p2),
    .g_out (gd),
    .p_out (pd)
  );

  logic unused_pd;
  assign unused_pd = ^pd;

  assign sum = pb2 ^ {gd[WIDTH-2:0], pl2.cin};
  assign co  = gd[WIDTH-1];
  assign ov  = (pl2.a_msb == pl2.bp_msb) && (sum[WIDTH-1] != pl2.a_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else begin
      out_valid <= pl2.valid;
      if (pl2.valid) begin
        s    <= sum;
        cout <= co;
        ovf  <= ov;
        if ((pl2.mode == MODE_ACC) || (pl2.mode == MODE_LOAD)) acc <= sum;
      end
    end
  end

  // busy reaches 0 on the same edge the ACC/LOAD result lands in acc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 2'd0;
    end else if (take && mode[1]) begin
      busy <= 2'(PIPE);
    end else if (busy != 2'd0) begin
      busy <= busy - 2'd1;
    end
  end

endmodule

// File: tb/tb_bk_pipe_adder.sv
// tb/tb_bk_pipe_adder.sv - self-checking bench for bk_pipe_adder at WIDTH=16, PIPE=2
module tb_bk_pipe_adder;
  import bk_adder_pkg::*;

  localparam int W = 16;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         out_valid;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic [W-1:0] acc;

  bk_pipe_adder #(.WIDTH(W), .PIPE(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .mode      (mode),
    .out_valid (out_valid),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic [W-1:0] acc;
  } exp_t;

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         ci;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           passed = 0;
  int           total = 0;
  int           blocked_until = 0;
  logic [W-1:0] model_acc = '0;
  logic [W-1:0] last_s = '0;
  logic [W-1:0] corners [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // arithmetic reference: unsigned sum for s/cout, signed sum range for ovf
  function automatic void ref_model(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                                    input logic [W-1:0] accv, input logic ci,
                                    output logic [W-1:0] rs, output logic rc, output logic ro);
    int ua, ub, uacc, sa, sb, sacc, ic, t, sr;
    ua   = {16'b0, av};
    ub   = {16'b0, bv};
    uacc = {16'b0, accv};
    sa   = {{16{av[15]}}, av};
    sb   = {{16{bv[15]}}, bv};
    sacc = {{16{accv[15]}}, accv};
    ic   = {31'b0, ci};
    case (m)
      MODE_ADD: begin t = ua + ub + ic;       sr = sa + sb + ic;   end
      MODE_SUB: begin t = ua - ub + 65536;    sr = sa - sb;        end
      MODE_ACC: begin t = ua + uacc + ic;     sr = sa + sacc + ic; end
      default:  begin t = ua;                 sr = sa;             end
    endcase
    rs = t[W-1:0];
    rc = t[W];
    ro = (sr > 32767) || (sr < -32768);
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("no_spurious_out_valid", {63'b0, out_valid}, 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk("latency", cyc, mon_e.due);
        chk("s", s, mon_e.s);
        chk("cout", cout, mon_e.co);
        chk("ovf", ovf, mon_e.ov);
        chk("acc", acc, mon_e.acc);
        last_s = s;
      end
    end else begin
      chk("s_hold", s, last_s);
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("result_present", {63'b0, out_valid}, 64'd1);
        q.delete(0);
      end
    end
  end

  // presents one op at a negedge, holds it until accepted, returns at the negedge after acceptance
  task automatic do_op(input vec_t v, input bit use_model);
    exp_t         e;
    int           tries;
    logic [W-1:0] rs;
    logic         rc, ro;
    if (use_model) begin
      ref_model(v.m, v.av, v.bv, model_acc, v.ci, rs, rc, ro);
      v.es = rs;
      v.ec = rc;
      v.eo = ro;
    end
    mode     = v.m;
    a        = v.av;
    b        = v.bv;
    cin      = v.ci;
    in_valid = 1'b1;
    tries    = 0;
    forever begin
      chk("in_ready", {63'b0, in_ready}, {63'b0, (cyc >= blocked_until)});
      if (in_ready) begin
        e.due = cyc + 1 + P;
        e.s   = v.es;
        e.co  = v.ec;
        e.ov  = v.eo;
        if (v.m == MODE_ACC || v.m == MODE_LOAD) begin
          model_acc     = v.es;
          blocked_until = cyc + 1 + P;
        end
        e.acc = model_acc;
        q.push_back(e);
        @(negedge clk);
        return;
      end
      tries++;
      if (tries > 2 * P + 2) begin
        chk("accept_timeout", {63'b0, in_ready}, 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) chk("drain", q.size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    vec_t tab [14];
    vec_t v;

    tab[0]  = '{MODE_ADD,  16'hABCD, 16'hDCBA, 1'b0, 16'h8887, 1'b1, 1'b0};
    tab[1]  = '{MODE_SUB,  16'h1234, 16'h5678, 1'b0, 16'hBBBC, 1'b0, 1'b0};
    tab[2]  = '{MODE_ADD,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tab[3]  = '{MODE_ADD,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tab[4]  = '{MODE_ADD,  16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
    tab[5]  = '{MODE_ADD,  16'hFE01, 16'h001A, 1'b0, 16'hFE1B, 1'b0, 1'b0};
    tab[6]  = '{MODE_ADD,  16'h1234, 16'h5678, 1'b0, 16'h68AC, 1'b0, 1'b0};
    tab[7]  = '{MODE_ADD,  16'hFF24, 16'h001A, 1'b0, 16'hFF3E, 1'b0, 1'b0};
    tab[8]  = '{MODE_SUB,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tab[9]  = '{MODE_SUB,  16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0};
    tab[10] = '{MODE_LOAD, 16'h0005, 16'h1234, 1'b1, 16'h0005, 1'b0, 1'b0};
    tab[11] = '{MODE_ACC,  16'h0003, 16'hFFFF, 1'b0, 16'h0008, 1'b0, 1'b0};
    tab[12] = '{MODE_ACC,  16'h0003, 16'h0000, 1'b0, 16'h000B, 1'b0, 1'b0};
    tab[13] = '{MODE_ACC,  16'h0003, 16'h0000, 1'b0, 16'h000E, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_s", s, 64'd0);
    chk("rst_cout", {63'b0, cout}, 64'd0);
    chk("rst_ovf", {63'b0, ovf}, 64'd0);
    chk("rst_acc", acc, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) do_op(tab[i], 1'b0);
    drain();
    chk("acc_final", acc, 64'h000E);

    // reset one cycle after an accepted ACC: nothing from it may surface
    v = '{MODE_ACC, 16'h0003, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b0};
    do_op(v, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    model_acc     = '0;
    blocked_until = 0;
    last_s        = '0;
    #1;
    chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_s", s, 64'd0);
    chk("arst_cout", {63'b0, cout}, 64'd0);
    chk("arst_ovf", {63'b0, ovf}, 64'd0);
    chk("arst_acc", acc, 64'd0);
    chk("arst_in_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int n = 0; n < 1500; n++) begin
      v.m  = 2'($urandom_range(0, 3));
      v.av = 16'($urandom);
      v.bv = 16'($urandom);
      v.ci = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) v.av = corners[2'($urandom_range(0, 3))];
      if ($urandom_range(0, 7) == 0) v.bv = corners[2'($urandom_range(0, 3))];
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      do_op(v, 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
